// File: rtl/evo_xb_info_pkg.sv
// Shared types and constants for the EVO_XB_INFO scan sequencer.
// The index constants match the layout of the indirect info register.
package evo_xb_info_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD, RW, EMIT, FIN, ERR} scan_state_e;

  typedef enum logic {OP_WR, OP_RD} txn_op_e;

  localparam logic [7:0] XB_INFO_NUM_IDX = 8'd0;
  localparam logic [7:0] XB_INFO_VENDOR  = 8'd1;
  localparam logic [7:0] XB_INFO_MODEL   = 8'd2;
  localparam logic [7:0] XB_INFO_TYPE    = 8'd3;

  // The full 32-bit compare keeps a huge raw count from wrapping the 8-bit index.
  function automatic logic [7:0] clamp_count(input logic [31:0] raw,
                                             input logic [7:0]  max_entries);
    return (raw > {24'd0, max_entries}) ? max_entries : raw[7:0];
  endfunction

endpackage

// File: rtl/evo_csr_txn.sv
// Single-transaction Avalon-MM master: one write or read at a time, holding the
// strobe through waitrequest and timing the read-data return.
module evo_csr_txn
  import evo_xb_info_pkg::*;
#(
  parameter int CSR_AWIDTH     = 8,
  parameter int CSR_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  txn_op_e               op,
  input  logic [CSR_AWIDTH-1:0] addr,
  input  logic [CSR_DWIDTH-1:0] wdata,
  output logic                  accepted,
  output logic                  rdata_valid,
  output logic                  timeout,
  output logic [CSR_AWIDTH-1:0] avm_csr_address,
  output logic                  avm_csr_write,
  output logic [CSR_DWIDTH-1:0] avm_csr_writedata,
  output logic                  avm_csr_read,
  input  logic                  avm_csr_waitrequest,
  input  logic                  avm_csr_readdatavalid
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          waiting;
  logic [CW-1:0] wait_cnt;

  assign accepted    = (avm_csr_write | avm_csr_read) & ~avm_csr_waitrequest;
  assign rdata_valid = waiting & avm_csr_readdatavalid;
  // A valid beat in the last allowed cycle wins over the timeout.
  assign timeout     = waiting & ~avm_csr_readdatavalid &
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avm_csr_address   <= '0;
      avm_csr_write     <= 1'b0;
      avm_csr_writedata <= '0;
      avm_csr_read      <= 1'b0;
      waiting           <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      if (issue) begin
        avm_csr_address <= addr;
        avm_csr_write   <= (op == OP_WR);
        avm_csr_read    <= (op == OP_RD);
        if (op == OP_WR) avm_csr_writedata <= wdata;
      end else if (accepted) begin
        avm_csr_write <= 1'b0;
        avm_csr_read  <= 1'b0;
      end

      if (avm_csr_read && !avm_csr_waitrequest) begin
        waiting  <= 1'b1;
        wait_cnt <= '0;
      end else if (rdata_valid || timeout) begin
        waiting  <= 1'b0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/evo_xb_info_scan.sv
// Walks the indirect EVO_XB_INFO register: index 0 gives the entry count,
// then indices 1..N are written, read back and streamed out in order.
module evo_xb_info_scan
  import evo_xb_info_pkg::*;
#(
  parameter int                   CSR_AWIDTH     = 8,
  parameter int                   CSR_DWIDTH     = 32,
  parameter logic [CSR_AWIDTH-1:0] INFO_CSR_ADDR = 8'h0,
  parameter int                   MAX_ENTRIES    = 16,
  parameter int                   TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            num_entries,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_index,
  output logic [CSR_DWIDTH-1:0] out_data,
  output logic [CSR_AWIDTH-1:0] avm_csr_address,
  output logic                  avm_csr_write,
  output logic [CSR_DWIDTH-1:0] avm_csr_writedata,
  output logic                  avm_csr_read,
  input  logic                  avm_csr_waitrequest,
  input  logic                  avm_csr_readdatavalid,
  input  logic [CSR_DWIDTH-1:0] avm_csr_readdata
);

  scan_state_e state, next_state;
  logic [7:0]  idx, idx_next;
  logic        issue, cap_count, cap_beat;
  txn_op_e     op;
  logic        accepted, rdata_valid, timeout;
  logic [7:0]  count_clamped;

  assign count_clamped = clamp_count(avm_csr_readdata, 8'(MAX_ENTRIES));

  evo_csr_txn #(
    .CSR_AWIDTH    (CSR_AWIDTH),
    .CSR_DWIDTH    (CSR_DWIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .clk                  (clk),
    .rst                  (rst),
    .issue                (issue),
    .op                   (op),
    .addr                 (INFO_CSR_ADDR),
    .wdata                ({{(CSR_DWIDTH-8){1'b0}}, idx_next}),
    .accepted             (accepted),
    .rdata_valid          (rdata_valid),
    .timeout              (timeout),
    .avm_csr_address      (avm_csr_address),
    .avm_csr_write        (avm_csr_write),
    .avm_csr_writedata    (avm_csr_writedata),
    .avm_csr_read         (avm_csr_read),
    .avm_csr_waitrequest  (avm_csr_waitrequest),
    .avm_csr_readdatavalid(avm_csr_readdatavalid)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    idx_next   = idx;
    issue      = 1'b0;
    op         = OP_WR;
    cap_count  = 1'b0;
    cap_beat   = 1'b0;
    case (state)
      IDLE: if (start) begin
        idx_next   = XB_INFO_NUM_IDX;
        issue      = 1'b1;
        next_state = WR;
      end
      WR: if (accepted) begin
        issue      = 1'b1;
        op         = OP_RD;
        next_state = RD;
      end
      RD: if (accepted) next_state = RW;
      RW: if (rdata_valid) begin
        if (idx == XB_INFO_NUM_IDX) begin
          cap_count = 1'b1;
          if (count_clamped == 8'd0) begin
            next_state = FIN;
          end else begin
            idx_next   = 8'd1;
            issue      = 1'b1;
            next_state = WR;
          end
        end else begin
          cap_beat   = 1'b1;
          next_state = EMIT;
        end
      end else if (timeout) begin
        next_state = ERR;
      end
      EMIT: if (out_ready) begin
        if (idx == num_entries) begin
          next_state = FIN;
        end else begin
          idx_next   = idx + 8'd1;
          issue      = 1'b1;
          next_state = WR;
        end
      end
      FIN:     next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      num_entries <= 8'd0;
      out_valid   <= 1'b0;
      out_index   <= 8'd0;
      out_data    <= '0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
      busy  <= next_state inside {WR, RD, RW, EMIT};
      done  <= (next_state == FIN);
      error <= (next_state == ERR);
      if (cap_count) num_entries <= count_clamped;
      if (cap_beat) begin
        out_valid <= 1'b1;
        out_index <= idx;
        out_data  <= avm_csr_readdata;
      end else if (state == EMIT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_evo_xb_info_scan.sv
// Directed bench for evo_xb_info_scan: an Avalon slave model holding the info
// table, a stream monitor, and one task per scenario.
module tb_evo_xb_info_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [7:0]  num_entries;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_index;
  logic [31:0] out_data;
  logic [7:0]  avm_csr_address;
  logic        avm_csr_write;
  logic [31:0] avm_csr_writedata;
  logic        avm_csr_read;
  logic        avm_csr_waitrequest;
  logic        avm_csr_readdatavalid;
  logic [31:0] avm_csr_readdata;

  int checks = 0;
  int errors = 0;

  evo_xb_info_scan dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .num_entries          (num_entries),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_index            (out_index),
    .out_data             (out_data),
    .avm_csr_address      (avm_csr_address),
    .avm_csr_write        (avm_csr_write),
    .avm_csr_writedata    (avm_csr_writedata),
    .avm_csr_read         (avm_csr_read),
    .avm_csr_waitrequest  (avm_csr_waitrequest),
    .avm_csr_readdatavalid(avm_csr_readdatavalid),
    .avm_csr_readdata     (avm_csr_readdata)
  );

  always #5 clk = ~clk;

  // Slave table and behaviour knobs
  logic [31:0] mem [0:255];
  int          ws = 0;
  bit          ready_toggle = 0;
  bit          silent_en = 0;
  logic [7:0]  silent_idx = 8'd2;

  // Monitor logs
  logic [31:0] wr_log[$];
  logic [7:0]  beat_idx[$];
  logic [31:0] beat_data[$];
  int rd_cnt, done_cnt, err_cnt, busy_viol, bus_viol, stream_viol, rw_both;
  int cyc = 0, err_cyc = 0, rd_acc_cyc = 0;

  // Slave and monitor act on the falling edge, away from the DUT's active edge.
  initial begin
    int          ws_cnt;
    bit          rsp_pending, prev_wait, prev_stall;
    logic [31:0] rsp_data, pwd, pdata;
    logic [7:0]  cur_idx, pa, pidx;
    logic        pw, pr;
    ws_cnt = 0; rsp_pending = 0; prev_wait = 0; prev_stall = 0; cur_idx = 0;
    rsp_data = 0; pwd = 0; pdata = 0; pa = 0; pidx = 0; pw = 0; pr = 0;
    avm_csr_waitrequest = 0; avm_csr_readdatavalid = 0; avm_csr_readdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        ws_cnt = 0; rsp_pending = 0; prev_wait = 0; prev_stall = 0;
        avm_csr_waitrequest = 0; avm_csr_readdatavalid = 0; avm_csr_readdata = 0;
      end else begin
        avm_csr_readdatavalid = rsp_pending;
        avm_csr_readdata      = rsp_pending ? rsp_data : 32'h0;
        rsp_pending = 0;
        if (avm_csr_write && avm_csr_read) rw_both++;
        if (prev_wait && (avm_csr_write !== pw || avm_csr_read !== pr ||
                          avm_csr_address !== pa || avm_csr_writedata !== pwd))
          bus_viol++;
        if (avm_csr_write || avm_csr_read) begin
          if (avm_csr_address !== 8'h0) bus_viol++;
          if (ws_cnt < ws) begin
            avm_csr_waitrequest = 1; ws_cnt++;
          end else begin
            avm_csr_waitrequest = 0; ws_cnt = 0;
            if (avm_csr_write) begin
              wr_log.push_back(avm_csr_writedata);
              cur_idx = avm_csr_writedata[7:0];
            end else begin
              rd_cnt++;
              rd_acc_cyc = cyc;
              if (!(silent_en && cur_idx == silent_idx)) begin
                rsp_pending = 1; rsp_data = mem[cur_idx];
              end
            end
          end
        end else begin
          avm_csr_waitrequest = 0;
        end
        prev_wait = avm_csr_waitrequest;
        pw = avm_csr_write; pr = avm_csr_read; pa = avm_csr_address; pwd = avm_csr_writedata;

        if (ready_toggle) out_ready = ~out_ready;
        if (prev_stall && (out_valid !== 1'b1 || out_index !== pidx || out_data !== pdata))
          stream_viol++;
        if (out_valid && out_ready) begin
          beat_idx.push_back(out_index);
          beat_data.push_back(out_data);
        end
        prev_stall = out_valid && !out_ready;
        pidx = out_index; pdata = out_data;
        if (done)  begin done_cnt++; if (busy) busy_viol++; end
        if (error) begin err_cnt++; err_cyc = cyc; if (busy) busy_viol++; end
      end
    end
  end

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 + 32'(i);
    mem[0] = 32'd6;
    mem[1] = 32'h414C4F20;
    mem[2] = 32'h45564F20;
    mem[3] = 32'h53455256;
    mem[4] = 32'hFFFFFFFF;
    mem[5] = 32'hC0FFEE01;
    mem[6] = 32'h54455354;
  endtask

  task automatic clear_logs();
    wr_log.delete(); beat_idx.delete(); beat_data.delete();
    rd_cnt = 0; done_cnt = 0; err_cnt = 0; busy_viol = 0;
    bus_viol = 0; stream_viol = 0; rw_both = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_cnt == 0 && err_cnt == 0) begin
      errors++; $display("FAIL wait_end: no done/error after %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, error, out_valid, avm_csr_write, avm_csr_read} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {busy, done, error, out_valid, avm_csr_write, avm_csr_read});
    end
    checks++;
    if ({avm_csr_address, avm_csr_writedata, num_entries, out_index, out_data} !== '0) begin
      errors++; $display("FAIL reset_buses: got addr=%h wd=%h num=%0d idx=%0d data=%h want all 0",
                         avm_csr_address, avm_csr_writedata, num_entries, out_index, out_data);
    end
  endtask

  task automatic test_basic();
    clear_logs(); load_default();
    ws = 0; ready_toggle = 0; out_ready = 1; silent_en = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_end(500);
    checks++;
    if (wr_log.size() != 7) begin
      errors++; $display("FAIL basic_nwr: got %0d want 7", wr_log.size());
    end
    for (int i = 0; i < wr_log.size() && i < 7; i++) begin
      checks++;
      if (wr_log[i] !== 32'(i)) begin
        errors++; $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_log[i], i);
      end
    end
    checks++;
    if (rd_cnt != 7) begin errors++; $display("FAIL basic_nrd: got %0d want 7", rd_cnt); end
    checks++;
    if (num_entries !== 8'd6) begin
      errors++; $display("FAIL basic_num: got %0d want 6", num_entries);
    end
    checks++;
    if (beat_idx.size() != 6) begin
      errors++; $display("FAIL basic_nbeats: got %0d want 6", beat_idx.size());
    end
    for (int i = 0; i < beat_idx.size() && i < 6; i++) begin
      checks++;
      if (beat_idx[i] !== 8'(i + 1) || beat_data[i] !== mem[i + 1]) begin
        errors++; $display("FAIL basic_beat[%0d]: got %0d/%h want %0d/%h",
                           i, beat_idx[i], beat_data[i], i + 1, mem[i + 1]);
      end
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || busy_viol != 0) begin
      errors++; $display("FAIL basic_done: got done=%0d err=%0d busyviol=%0d want 1/0/0",
                         done_cnt, err_cnt, busy_viol);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_zero_count();
    clear_logs(); load_default(); mem[0] = 32'd0;
    pulse_start();
    wait_end(200);
    checks++;
    if (wr_log.size() != 1 || rd_cnt != 1) begin
      errors++; $display("FAIL zero_bus: got wr=%0d rd=%0d want 1/1", wr_log.size(), rd_cnt);
    end
    checks++;
    if (num_entries !== 8'd0 || beat_idx.size() != 0) begin
      errors++; $display("FAIL zero_stream: got num=%0d beats=%0d want 0/0",
                         num_entries, beat_idx.size());
    end
    checks++;
    if (done_cnt != 1 || busy_viol != 0) begin
      errors++; $display("FAIL zero_done: got done=%0d busyviol=%0d want 1/0", done_cnt, busy_viol);
    end
  endtask

  task automatic test_clamp();
    clear_logs(); load_default(); mem[0] = 32'h0000_0100;
    pulse_start();
    wait_end(1000);
    checks++;
    if (num_entries !== 8'd16) begin
      errors++; $display("FAIL clamp_num: got %0d want 16", num_entries);
    end
    checks++;
    if (beat_idx.size() != 16 || wr_log.size() != 17) begin
      errors++; $display("FAIL clamp_counts: got beats=%0d wr=%0d want 16/17",
                         beat_idx.size(), wr_log.size());
    end
    checks++;
    if (beat_idx.size() == 0 || beat_idx[beat_idx.size() - 1] !== 8'd16 ||
        beat_data[beat_data.size() - 1] !== mem[16]) begin
      errors++; $display("FAIL clamp_last: got beats=%0d want last index 16 data %h",
                         beat_idx.size(), mem[16]);
    end
  endtask

  task automatic test_waits_backpressure();
    clear_logs(); load_default();
    ws = 3; out_ready = 1; ready_toggle = 1;
    pulse_start();
    wait_end(2000);
    ready_toggle = 0; out_ready = 1; ws = 0;
    checks++;
    if (bus_viol != 0 || rw_both != 0) begin
      errors++; $display("FAIL wait_bus: got holdviol=%0d rw_both=%0d want 0/0", bus_viol, rw_both);
    end
    checks++;
    if (stream_viol != 0) begin
      errors++; $display("FAIL wait_stall: got %0d unstable stalls want 0", stream_viol);
    end
    checks++;
    if (beat_idx.size() != 6 || wr_log.size() != 7) begin
      errors++; $display("FAIL wait_counts: got beats=%0d wr=%0d want 6/7",
                         beat_idx.size(), wr_log.size());
    end
    for (int i = 0; i < beat_idx.size() && i < 6; i++) begin
      checks++;
      if (beat_idx[i] !== 8'(i + 1) || beat_data[i] !== mem[i + 1]) begin
        errors++; $display("FAIL wait_beat[%0d]: got %0d/%h want %0d/%h",
                           i, beat_idx[i], beat_data[i], i + 1, mem[i + 1]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL wait_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    clear_logs(); load_default(); silent_en = 1; silent_idx = 8'd2;
    pulse_start();
    wait_end(500);
    silent_en = 0;
    checks++;
    if (err_cnt != 1 || done_cnt != 0 || busy_viol != 0) begin
      errors++; $display("FAIL to_pulse: got err=%0d done=%0d busyviol=%0d want 1/0/0",
                         err_cnt, done_cnt, busy_viol);
    end
    // 64 RW cycles after the accept, then the ERR cycle carrying the pulse.
    checks++;
    if (err_cyc - rd_acc_cyc != 65) begin
      errors++; $display("FAIL to_latency: got %0d want 65", err_cyc - rd_acc_cyc);
    end
    checks++;
    if (beat_idx.size() != 1 || (beat_idx.size() == 1 &&
        (beat_idx[0] !== 8'd1 || beat_data[0] !== mem[1]))) begin
      errors++; $display("FAIL to_beat1: got beats=%0d want 1 beat idx 1 data %h",
                         beat_idx.size(), mem[1]);
    end
    checks++;
    if (busy !== 1'b0 || num_entries !== 8'd6) begin
      errors++; $display("FAIL to_idle: got busy=%b num=%0d want 0/6", busy, num_entries);
    end
    clear_logs();
    pulse_start();
    wait_end(500);
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || beat_idx.size() != 6) begin
      errors++; $display("FAIL to_restart: got done=%0d err=%0d beats=%0d want 1/0/6",
                         done_cnt, err_cnt, beat_idx.size());
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    bit hit;
    clear_logs(); load_default(); ws = 3;
    pulse_start();
    n = 0; hit = 0;
    while (!hit && n < 500) begin
      @(negedge clk); #1; n++;
      if (avm_csr_read && wr_log.size() == 4 && wr_log[3] == 32'd3) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: read of index 3 not seen"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, out_valid, avm_csr_write, avm_csr_read} !== 6'b0 ||
        {avm_csr_address, avm_csr_writedata, num_entries, out_index, out_data} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got busy=%b rd=%b wr=%b num=%0d idx=%0d want all 0",
                         busy, avm_csr_read, avm_csr_write, num_entries, out_index);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || err_cnt != 0 || wr_log.size() != 4) begin
      errors++; $display("FAIL rst_mid_quiet: got done=%0d err=%0d wr=%0d want 0/0/4",
                         done_cnt, err_cnt, wr_log.size());
    end
    ws = 0;
    clear_logs();
    pulse_start();
    wait_end(500);
    checks++;
    if (wr_log.size() != 7 || (wr_log.size() > 0 && wr_log[0] !== 32'd0) ||
        beat_idx.size() != 6 || done_cnt != 1) begin
      errors++; $display("FAIL rst_mid_rescan: got wr=%0d beats=%0d done=%0d want 7/6/1 from index 0",
                         wr_log.size(), beat_idx.size(), done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    load_default(); clear_logs();
    repeat (3) @(negedge clk);
    test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_zero_count();
    test_clamp();
    test_waits_backpressure();
    test_timeout();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
